cadr_sel_arbiter: RTL and testbench
===================================

Name: cadr_sel_arbiter

Overview:
- Round-robin arbiter and sequencer for a 3-to-8 active-low select decoder that is shared by eight requesters.
- Picks one requester and presents its 3-bit code during a setup cycle. It then asserts the decoder enable, holds the grant until the requester finishes or a hold timeout expires, and inserts a dead cycle before the next grant.
- Guarantees that the decoded selects are glitch-free and never overlap. Sits between the requesting device controllers and the bus/device select decode.

Parameters:
- HOLD_MAX, 16, maximum GRANT cycles before forced release (2..255).
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  8  request per requester, active high, level; bit i = requester i.
- done  input  1  pulse from the granted requester marking end of transfer.
- sel_code  output  3  {C,B,A} code of the current owner; drives the decoder address.
- sel_en  output  1  decoder enable (G1); high only in GRANT.
- sel_n  output  8  decoded active-low selects; sel_n[i]=0 iff sel_en and sel_code==i, otherwise 8'hFF.
- gnt  output  8  one-hot grant, registered; equals ~sel_n.
- busy  output  1  high in SETUP, GRANT and RELEASE.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE, ptr=0, cnt=0.
  - sel_code=0, sel_en=0, sel_n=8'hFF, gnt=0, busy=0, timeout=0.
  - Asserting reset in any state returns to these values immediately; there is no drain.
- States: IDLE, SETUP, GRANT, RELEASE. All outputs are registered.
- IDLE:
  - If req!=0, pick the winner: the first set bit scanning ptr, ptr+1, ... ptr+7 (mod 8).
  - Load sel_code=winner and go to SETUP.
  - If req==0, stay in IDLE; sel_code holds its last value.
- SETUP (exactly one cycle): sel_en=0, sel_n=FF, busy=1.
  - If req[sel_code] is still high, go to GRANT and clear cnt.
  - If req[sel_code] has dropped, go to IDLE with ptr unchanged (abort, no grant issued).
- GRANT:
  - sel_en=1, sel_n/gnt decoded from sel_code; cnt increments each cycle, saturating.
  - Exit to RELEASE on the first cycle in which any of these holds: done=1, req[sel_code]=0, or cnt==HOLD_MAX-1.
  - Grant duration is therefore 1..HOLD_MAX cycles.
  - When the exit is by count, with done=0 and req still high, pulse timeout=1 in the first RELEASE cycle.
  - done and a timeout in the same cycle count as a normal completion (no timeout pulse).
  - done received outside GRANT is ignored.
  - sel_code never changes while sel_en=1.
- RELEASE (exactly one cycle): sel_en=0, sel_n=FF, busy=1.
  - ptr = sel_code+1 mod 8 (wraps 7 to 0).
  - Go to IDLE; arbitration resumes there, so the minimum back-to-back spacing is IDLE, SETUP, GRANT, RELEASE (4 cycles per grant of length 1).
- Fairness: a requester that holds req continuously is granted within 7 other grants.
- Requests are not latched; a req pulse seen only while the arbiter is busy is lost.

Decomposition:
- Shared package cadr_sel_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SETUP=2'd1, ST_GRANT=2'd2, ST_RELEASE=2'd3;
  - SEL_NONE=8'hFF.
- One sub-module, cadr_rr_pick8: combinational rotate-priority encoder (req[7:0], ptr[2:0] -> winner[2:0], any). It is independently testable.
- The decoded sel_n is generated internally with its own register; the 74S138 part model is not instantiated, so outputs stay registered and glitch-free.

Test Plan:
- Reset mid-GRANT: requester 3 granted, reset_n low for 1 cycle, then high -> sel_n=FF, gnt=0, busy=0 immediately; ptr=0, so with req=8'h09 the next winner is 0.
- Single request: req=8'h20 held; done pulsed on the 3rd GRANT cycle -> sel_code=5 in SETUP, sel_n=8'hDF for 3 cycles, one FF RELEASE cycle, then ptr=6.
- Round-robin wrap: req=8'h81 held, done each GRANT cycle -> grants alternate 0,7,0,7; each grant is separated by RELEASE+IDLE+SETUP with sel_en=0 throughout.
- Timeout: HOLD_MAX=4, req=8'h04 held, no done -> exactly 4 GRANT cycles of sel_n=8'hFB, timeout=1 for one cycle in RELEASE; the requester is re-granted after IDLE/SETUP.
- Abort in SETUP: req=8'h02 for 1 cycle only -> SETUP shows sel_code=1, no GRANT cycle (sel_n stays FF), return to IDLE with ptr still 0.
- Simultaneous done and timeout: HOLD_MAX=2, done on the 2nd GRANT cycle -> RELEASE with timeout=0.

Source files
------------

// File: rtl/cadr_sel_pkg.sv
// Shared types and constants for the round-robin select-decoder arbiter.
package cadr_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [7:0] SEL_NONE = 8'hFF;

endpackage

// File: rtl/cadr_rr_pick8.sv
// Rotating-priority encoder: first set request bit at or after ptr_i, mod 8.
module cadr_rr_pick8 (
  input  logic [7:0] req_i,
  input  logic [2:0] ptr_i,
  output logic [2:0] winner_o,
  output logic       any_o
);

  logic [7:0] rot;
  logic [2:0] offset;

  // rot[k] is the request k positions after the pointer; 3-bit add wraps mod 8
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rot[gi] = req_i[ptr_i + 3'(gi)];
    end
  endgenerate

  always_comb begin
    offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) offset = 3'(k);
    end
  end

  assign winner_o = ptr_i + offset;
  assign any_o    = |req_i;

endmodule

// File: rtl/cadr_sel_arbiter.sv
// Round-robin arbiter/sequencer driving a shared 3-to-8 active-low select decode.
// Every output is a flop, so selects never glitch and never overlap.
module cadr_sel_arbiter
  import cadr_sel_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel_code,
  output logic       sel_en,
  output logic [7:0] sel_n,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         code_q, code_d;
  logic               en_q, en_d;
  logic [7:0]         sel_n_q, sel_n_d;
  logic [7:0]         gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [2:0]         pick_winner;
  logic               pick_any;
  logic               owner_req;
  logic               hold_expired;

  cadr_rr_pick8 u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_winner),
    .any_o    (pick_any)
  );

  assign owner_req    = req[code_q];
  assign hold_expired = (cnt_q == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          code_d  = pick_winner;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (owner_req) begin
          state_d = ST_GRANT;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (done || !owner_req || hold_expired) begin
          state_d   = ST_RELEASE;
          // a completion that coincides with the limit is not a forced release
          timeout_d = hold_expired && !done && owner_req;
        end
      end
      ST_RELEASE: begin
        ptr_d   = code_q + 3'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign en_d   = (state_d == ST_GRANT);
  assign busy_d = (state_d != ST_IDLE);

  // decode from next-state values so the select flops line up with sel_en
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign sel_n_d[gi] = !(en_d && (code_d == 3'(gi)));
    end
  endgenerate

  assign gnt_d = ~sel_n_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'd0;
      cnt_q     <= '0;
      code_q    <= 3'd0;
      en_q      <= 1'b0;
      sel_n_q   <= SEL_NONE;
      gnt_q     <= 8'h00;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      en_q      <= en_d;
      sel_n_q   <= sel_n_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign sel_code = code_q;
  assign sel_en   = en_q;
  assign sel_n    = sel_n_q;
  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_cadr_sel_arbiter.sv
// Randomized scoreboard bench for cadr_sel_arbiter against a transaction-level model.
module tb_cadr_sel_arbiter;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] sel_code;
  logic       sel_en;
  logic [7:0] sel_n;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  cadr_sel_arbiter #(.HOLD_MAX(HM), .CNT_W(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .done     (done),
    .sel_code (sel_code),
    .sel_en   (sel_en),
    .sel_n    (sel_n),
    .gnt      (gnt),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int owner;
    int len;
    bit to;
  } exp_t;

  exp_t gq[$];
  int   setup_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_ptr = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [7:0] p, input int ptr);
    for (int o = 0; o < 8; o++) begin
      if (p[(ptr + o) % 8]) return (ptr + o) % 8;
    end
    return -1;
  endfunction

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  // Monitor: pops expectations when the DUT enters SETUP or starts/ends a grant
  exp_t cur;
  bit   in_g = 0;
  bit   prev_busy = 0;
  bit   prev_en = 0;
  int   glen = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_g = 0;
      prev_busy = 0;
      prev_en = 0;
    end else begin
      if (busy && !prev_busy) begin
        if (setup_q.size() == 0) begin
          check("unexpected_setup", 1, 0);
        end else begin
          check("setup_code", int'(sel_code), setup_q.pop_front());
          check("setup_en", int'(sel_en), 0);
          check("setup_sel_n", int'(sel_n), 8'hFF);
        end
      end
      if (sel_en && !prev_en) begin
        if (gq.size() == 0) begin
          check("unexpected_grant", 1, 0);
          in_g = 0;
        end else begin
          cur = gq.pop_front();
          in_g = 1;
          glen = 0;
        end
      end
      if (sel_en && in_g) begin
        glen++;
        check("grant_code", int'(sel_code), cur.owner);
        check("grant_gnt", int'(gnt), (1 << cur.owner));
        check("grant_sel_n", int'(sel_n), (~(1 << cur.owner)) & 8'hFF);
        check("grant_busy", int'(busy), 1);
      end
      if (!sel_en) begin
        check("idle_sel_n", int'(sel_n), 8'hFF);
        check("idle_gnt", int'(gnt), 0);
      end
      if (!sel_en && prev_en && in_g) begin
        check("grant_len", glen, cur.len);
        check("timeout_pulse", int'(timeout), int'(cur.to));
        check("release_busy", int'(busy), 1);
        in_g = 0;
      end else if (timeout) begin
        check("spurious_timeout", int'(timeout), 0);
      end
      prev_busy = busy;
      prev_en = sel_en;
    end
  end

  // One arbitration: drive pattern in IDLE; d/r are the GRANT cycle numbers of done / owner-drop
  task automatic run_txn(input logic [7:0] pattern, input int d, input int r, input bit abort);
    int w;
    int n;
    int k;
    w = model_winner(pattern, model_ptr);
    setup_q.push_back(w);
    if (!abort) gq.push_back('{owner: w, len: min3(d, r, HM), to: (d > HM && r > HM)});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 20);
    if (busy) check("wait_idle_timeout", 1, 0);
    req  = pattern;
    done = 1'($urandom_range(0, 1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 20);
    done = 1'b0;
    if (!busy) begin
      check("wait_setup_timeout", 1, 0);
      req = 8'h00;
      return;
    end
    if (abort) begin
      req = 8'h00;
      return;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel_en && n < 20);
    if (!sel_en) begin
      check("wait_grant_timeout", 1, 0);
      req = 8'h00;
      return;
    end
    k = 1;
    while (sel_en && k <= HM + 2) begin
      done = (k == d);
      if (k == r) req[w] = 1'b0;
      @(negedge clk);
      k++;
    end
    done = 1'b0;
    req  = 8'h00;
    if (sel_en) check("grant_end_timeout", 1, 0);
    model_ptr = (w + 1) % 8;
  endtask

  task automatic reset_mid_grant();
    int n;
    setup_q.push_back(model_winner(8'h08, model_ptr));
    gq.push_back('{owner: 3, len: 0, to: 0});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 20);
    req = 8'h08;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel_en && n < 20);
    check("pre_reset_grant", int'(gnt), 8'h08);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_sel_n", int'(sel_n), 8'hFF);
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sel_en", int'(sel_en), 0);
    check("rst_code", int'(sel_code), 0);
    req = 8'h00;
    @(negedge clk);
    #2 reset_n = 1'b1;
    gq.delete();
    setup_q.delete();
    model_ptr = 0;
  endtask

  initial begin
    int d;
    int r;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sel_n", int'(sel_n), 8'hFF);
    check("reset_gnt", int'(gnt), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_sel_en", int'(sel_en), 0);
    check("reset_code", int'(sel_code), 0);
    #2 reset_n = 1'b1;

    run_txn(8'h20, 3, 99, 0);
    $display("txn single req=20 ptr_now=%0d", model_ptr);
    for (int i = 0; i < 4; i++) begin
      run_txn(8'h81, 1, 99, 0);
      $display("txn wrap req=81 ptr_now=%0d", model_ptr);
    end
    run_txn(8'h04, 99, 99, 0);
    $display("txn timeout req=04 ptr_now=%0d", model_ptr);
    run_txn(8'h02, 99, 99, 1);
    $display("txn abort req=02 ptr_now=%0d", model_ptr);
    run_txn(8'h04, HM, 99, 0);
    $display("txn done_at_limit req=04 ptr_now=%0d", model_ptr);
    run_txn(8'h10, 99, 2, 0);
    $display("txn req_drop req=10 ptr_now=%0d", model_ptr);
    reset_mid_grant();
    $display("txn reset_mid_grant ptr_now=%0d", model_ptr);
    run_txn(8'h09, 1, 99, 0);
    $display("txn post_reset req=09 ptr_now=%0d", model_ptr);

    for (int i = 0; i < 150; i++) begin
      logic [7:0] p;
      bit ab;
      p  = 8'($urandom_range(1, 255));
      d  = $urandom_range(1, HM + 2);
      r  = $urandom_range(1, HM + 3);
      ab = ($urandom_range(0, 9) == 0);
      run_txn(p, d, r, ab);
      $display("txn rand %0d req=%02h d=%0d r=%0d abort=%0d ptr_now=%0d", i, p, d, r, ab, model_ptr);
    end

    repeat (4) @(negedge clk);
    check("grant_queue_drained", gq.size(), 0);
    check("setup_queue_drained", setup_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
